// File: rtl/imem_ctrl.sv
// Instruction-memory responder: serves fetch PCs from a word-addressed SRAM array.
// Latency: LATENCY cycles from accept to response, one response per accepted request, in order.
// Backpressure: req_ready_o drops only while the boot loader writes; flush_i kills in-flight fetches.
module imem_ctrl #(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic [31:0] req_addr_i,
  output logic        req_ready_o,
  input  logic        flush_i,
  input  logic        load_en_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_data_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_instr_o,
  output logic [31:0] rsp_addr_o,
  output logic        rsp_err_o,
  output logic [15:0] err_cnt_o
);

  localparam int          AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("imem_ctrl: LATENCY must be in 1..4");
  end

  // Aligned, at or above the base, and inside the array.
  function automatic logic addr_legal(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return (a[1:0] == 2'b00) && (a >= BASE_ADDR) && ((off >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE_ADDR;
    return off[AW+1:2];
  endfunction

  logic [31:0] mem [DEPTH];

  // Stage 0 is the array read register; stage LATENCY-1 drives the outputs.
  logic        vld_q  [LATENCY];
  logic        err_q  [LATENCY];
  logic [31:0] addr_q [LATENCY];
  logic [31:0] dat_q  [LATENCY];
  logic [15:0] err_cnt_q;

  logic accept;
  logic req_ok;
  logic load_ok;

  assign req_ready_o = ~load_en_i;
  assign accept      = req_valid_i & req_ready_o & ~flush_i;
  assign req_ok      = addr_legal(req_addr_i);
  assign load_ok     = addr_legal(load_addr_i);

  // Array write/read and the data shift pipeline; contents survive reset, so no reset here.
  always_ff @(posedge clk) begin
    if (load_en_i && load_ok) begin
      mem[word_idx(load_addr_i)] <= load_data_i;
    end
    if (accept && req_ok) begin
      dat_q[0] <= mem[word_idx(req_addr_i)];
    end
    for (int i = 1; i < LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  // Valid/addr/err pipeline; flush clears every valid bit, addr/err only advance with a live entry
  // so the response address holds its last presented value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_q[i]  <= 1'b0;
        err_q[i]  <= 1'b0;
        addr_q[i] <= 32'h0;
      end
    end else begin
      vld_q[0] <= accept;
      if (accept) begin
        addr_q[0] <= req_addr_i;
        err_q[0]  <= ~req_ok;
      end
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1] & ~flush_i;
        if (vld_q[i-1] && !flush_i) begin
          addr_q[i] <= addr_q[i-1];
          err_q[i]  <= err_q[i-1];
        end
      end
    end
  end

  assign rsp_valid_o = vld_q[LATENCY-1];
  assign rsp_err_o   = vld_q[LATENCY-1] & err_q[LATENCY-1];
  assign rsp_instr_o = (vld_q[LATENCY-1] && !err_q[LATENCY-1]) ? dat_q[LATENCY-1] : NOP;
  assign rsp_addr_o  = addr_q[LATENCY-1];

  // Saturating count of errored responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'h0;
    end else if (rsp_err_o && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'h1;
    end
  end

  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Testbench for imem_ctrl: table-driven cycle vectors plus hand-written reset and saturation runs.
// Expected responses are queued at drive time with a due cycle and compared when that cycle comes.
// Inputs change on the falling edge; outputs are sampled there, away from the rising edge.
module tb_imem_ctrl;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        req_valid_i;
  logic [31:0] req_addr_i;
  logic        req_ready_o;
  logic        flush_i;
  logic        load_en_i;
  logic [31:0] load_addr_i;
  logic [31:0] load_data_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_instr_o;
  logic [31:0] rsp_addr_o;
  logic        rsp_err_o;
  logic [15:0] err_cnt_o;

  imem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .flush_i(flush_i),
    .load_en_i(load_en_i), .load_addr_i(load_addr_i), .load_data_i(load_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_instr_o(rsp_instr_o), .rsp_addr_o(rsp_addr_o),
    .rsp_err_o(rsp_err_o), .err_cnt_o(err_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] addr;
    logic        ld;
    logic [31:0] laddr;
    logic [31:0] ldat;
    logic        fl;
    logic        exp_rdy;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[$];
  logic [31:0] ref_mem [int];
  int          cyc;
  int          total;
  int          bad;
  logic [15:0] exp_cnt;
  logic [31:0] last_addr;

  function automatic vec_t mk(input logic vld, input logic [31:0] addr, input logic ld,
                              input logic [31:0] laddr, input logic [31:0] ldat,
                              input logic fl, input logic exp_rdy);
    vec_t v;
    v.vld = vld; v.addr = addr; v.ld = ld; v.laddr = laddr;
    v.ldat = ldat; v.fl = fl; v.exp_rdy = exp_rdy;
    return v;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= BASE) && (((a - BASE) / 4) < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive the vector, update the model, advance.
  task automatic step(input vec_t v);
    exp_t e;
    logic ok;
    chk("err_cnt", 32'(err_cnt_o), 32'(exp_cnt));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("rsp_instr", rsp_instr_o, e.instr);
      chk("rsp_addr", rsp_addr_o, e.addr);
      chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
      last_addr = e.addr;
      if (e.err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'h1;
    end else begin
      chk("idle_valid", 32'(rsp_valid_o), 32'd0);
      chk("idle_instr", rsp_instr_o, NOP);
      chk("idle_err", 32'(rsp_err_o), 32'd0);
      chk("idle_addr", rsp_addr_o, last_addr);
    end
    req_valid_i = v.vld;
    req_addr_i  = v.addr;
    load_en_i   = v.ld;
    load_addr_i = v.laddr;
    load_data_i = v.ldat;
    flush_i     = v.fl;
    #1;
    chk("req_ready", 32'(req_ready_o), 32'(v.exp_rdy));
    if (v.fl) sbq.delete();
    if (v.vld && !v.ld && !v.fl) begin
      ok      = legal(v.addr);
      e.due   = cyc + LAT;
      e.addr  = v.addr;
      e.err   = !ok;
      e.instr = ok ? ref_mem[widx(v.addr)] : NOP;
      sbq.push_back(e);
    end
    if (v.ld && legal(v.laddr)) ref_mem[widx(v.laddr)] = v.ldat;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);
    step(mk(1'b1, a, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(mk(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; exp_cnt = 16'h0; last_addr = 32'h0;
    rst_n = 1'b0; req_valid_i = 1'b0; req_addr_i = 32'h0; flush_i = 1'b0;
    load_en_i = 1'b0; load_addr_i = 32'h0; load_data_i = 32'h0;

    // Reset state
    #2;
    chk("rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_instr", rsp_instr_o, NOP);
    chk("rst_addr", rsp_addr_o, 32'h0);
    chk("rst_err", 32'(rsp_err_o), 32'd0);
    chk("rst_cnt", 32'(err_cnt_o), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    //            vld  addr          ld   laddr         ldat          fl   rdy
    tbl.push_back(mk(0, 32'h0,       1, 32'h0,       32'h11,       0, 0));
    tbl.push_back(mk(0, 32'h0,       1, 32'h4,       32'h22,       0, 0));
    tbl.push_back(mk(0, 32'h0,       1, 32'h8,       32'h33,       0, 0));
    tbl.push_back(mk(0, 32'h0,       1, 32'hC,       32'h44,       0, 0));
    tbl.push_back(mk(0, 32'h0,       1, 32'h40,      32'h55,       0, 0));
    tbl.push_back(mk(0, 32'h0,       1, 32'hFFC,     32'h66,       0, 0));
    tbl.push_back(mk(0, 32'h0,       1, 32'h1000,    32'hDEAD,     0, 0)); // out of range: ignored
    tbl.push_back(mk(0, 32'h0,       1, 32'h5,       32'hBEEF,     0, 0)); // misaligned: ignored
    tbl.push_back(mk(1, 32'h0,       0, 32'h0,       32'h0,        0, 1)); // back-to-back stream
    tbl.push_back(mk(1, 32'h4,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(1, 32'h8,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(1, 32'hC,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(1, 32'hFFC,     0, 32'h0,       32'h0,        0, 1)); // last legal word
    tbl.push_back(mk(1, 32'h6,       0, 32'h0,       32'h0,        0, 1)); // misaligned
    tbl.push_back(mk(1, 32'h1000,    0, 32'h0,       32'h0,        0, 1)); // 4*DEPTH
    tbl.push_back(mk(1, 32'h4,       0, 32'h0,       32'h0,        0, 1)); // illegal load left word 1 alone
    tbl.push_back(mk(0, 32'h0,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(0, 32'h0,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(1, 32'h0,       1, 32'h0,       32'hAA,       0, 0)); // load wins over read
    tbl.push_back(mk(1, 32'h0,       0, 32'h0,       32'h0,        0, 1)); // read-after-load
    tbl.push_back(mk(0, 32'h0,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(0, 32'h0,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(1, 32'h0,       0, 32'h0,       32'h0,        0, 1)); // flush sequence
    tbl.push_back(mk(1, 32'h4,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(1, 32'h8,       0, 32'h0,       32'h0,        1, 1)); // jump: 4 killed, 8 dropped
    tbl.push_back(mk(1, 32'h40,      0, 32'h0,       32'h0,        0, 1)); // jump target
    tbl.push_back(mk(0, 32'h0,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(0, 32'h0,       0, 32'h0,       32'h0,        0, 1));
    tbl.push_back(mk(0, 32'h0,       0, 32'h0,       32'h0,        0, 1));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Error count seen so far: 0x6 and 0x1000
    chk("err_cnt_two", 32'(err_cnt_o), 32'd2);

    // Reset with two fetches in flight: word 0 on the outputs, word 4 in the read stage
    rd(32'h0);
    rd(32'h4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
    chk("mid_rst_instr", rsp_instr_o, NOP);
    chk("mid_rst_cnt", 32'(err_cnt_o), 32'd0);
    sbq.delete();
    exp_cnt = 16'h0;
    last_addr = 32'h0;
    req_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); cyc++; @(negedge clk);
      chk("in_rst_valid", 32'(rsp_valid_o), 32'd0);
    end
    rst_n = 1'b1;
    idle(4);
    rd(32'h40);
    rd(32'hC);
    rd(32'h0);
    idle(3);

    // Saturation of the error counter
    for (int i = 0; i < 65540; i++) step(mk(1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1));
    idle(3);
    chk("err_cnt_sat", 32'(err_cnt_o), 32'h0000_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
